// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates one shared RAM port between an instruction requester
// and a data requester. Data has fixed priority. A granted request is latched
// and replayed to the RAM until ramstate reports ACCESS. ERROR causes a
// one-cycle strobe drop followed by a retry. A grant-cycle counter aborts a
// transaction that never completes within TIMEOUT cycles.
//
// Optional build macro MEM_ARBITER_FAIR_EN: after a data access completes with
// an instruction request pending, the next arbitration favours the
// instruction side once.
//
// Handshake: a requester holds its REN/WEN high and watches its *wait output.
// The transaction is done in the single cycle where *wait is 0, and *load is
// valid only in that cycle. A request that drops mid-grant still completes at
// the RAM. Its wait-low pulse still happens and the requester ignores it.
module mem_arbiter #(
  parameter int TIMEOUT = 64,
  parameter int WORD_W  = 32
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              err,
  output logic [1:0]        o_dbg_state
);

  // Only ACCESS and ERROR change behaviour. FREE and BUSY both mean "keep waiting".
  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;

  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    IGRANT = 2'd1,
    DGRANT = 2'd2,
    ABORT  = 2'd3
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_addr;
  logic [WORD_W-1:0] r_store;
  logic              r_wr;
  logic              r_ren;
  logic              r_wen;
  logic              r_drop;   // strobes deliberately low for one cycle after ERROR
  logic              r_err;
  logic              r_hold;   // blocks arbitration in the cycle reset is released
`ifdef MEM_ARBITER_FAIR_EN
  logic              r_fair;   // instruction side owed one turn
`endif

  logic w_in_grant;
  logic w_live_access;
  logic w_i_done;
  logic w_d_done;
  logic w_d_req;

  assign w_in_grant    = (r_state == IGRANT) || (r_state == DGRANT);
  assign w_live_access = w_in_grant && !r_drop && (ramstate == RS_ACCESS);
  assign w_i_done      = w_live_access && (r_state == IGRANT);
  assign w_d_done      = w_live_access && (r_state == DGRANT);
  assign w_d_req       = dREN || dWEN;

  assign iwait       = !w_i_done;
  assign dwait       = !w_d_done;
  assign iload       = w_i_done ? ramload : '0;
  assign dload       = w_d_done ? ramload : '0;
  assign ramREN      = r_ren;
  assign ramWEN      = r_wen;
  assign ramaddr     = r_addr;
  assign ramstore    = r_store;
  assign err         = r_err;
  assign o_dbg_state = r_state;

  // Arbitration FSM: latch the winner, replay to RAM, handle retry and timeout.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_store <= '0;
      r_wr    <= 1'b0;
      r_ren   <= 1'b0;
      r_wen   <= 1'b0;
      r_drop  <= 1'b0;
      r_err   <= 1'b0;
      r_hold  <= 1'b1;
`ifdef MEM_ARBITER_FAIR_EN
      r_fair  <= 1'b0;
`endif
    end else begin
      r_err  <= 1'b0;
      r_hold <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!r_hold) begin
`ifdef MEM_ARBITER_FAIR_EN
            if (r_fair && iREN) begin
              r_state <= IGRANT;
              r_addr  <= iaddr;
              r_store <= '0;
              r_wr    <= 1'b0;
              r_ren   <= 1'b1;
              r_wen   <= 1'b0;
              r_cnt   <= '0;
              r_drop  <= 1'b0;
              r_fair  <= 1'b0;
            end else
`endif
            if (w_d_req) begin
              // A simultaneous read and write is served as a write.
              r_state <= DGRANT;
              r_addr  <= daddr;
              r_store <= dstore;
              r_wr    <= dWEN;
              r_ren   <= !dWEN;
              r_wen   <= dWEN;
              r_cnt   <= '0;
              r_drop  <= 1'b0;
`ifdef MEM_ARBITER_FAIR_EN
              r_fair  <= 1'b0;
`endif
            end else if (iREN) begin
              r_state <= IGRANT;
              r_addr  <= iaddr;
              r_store <= '0;
              r_wr    <= 1'b0;
              r_ren   <= 1'b1;
              r_wen   <= 1'b0;
              r_cnt   <= '0;
              r_drop  <= 1'b0;
`ifdef MEM_ARBITER_FAIR_EN
              r_fair  <= 1'b0;
`endif
            end
          end
        end
        IGRANT, DGRANT: begin
          if (w_live_access) begin
            r_state <= IDLE;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
`ifdef MEM_ARBITER_FAIR_EN
            r_fair  <= (r_state == DGRANT) && iREN;
`endif
          end else if (r_cnt == CNT_LAST) begin
            r_state <= ABORT;
            r_ren   <= 1'b0;
            r_wen   <= 1'b0;
            r_drop  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            // The counter keeps running across retries, so an ERROR loop still times out.
            r_cnt <= r_cnt + 1'b1;
            if (r_drop) begin
              r_drop <= 1'b0;
              r_ren  <= !r_wr;
              r_wen  <= r_wr;
            end else if (ramstate == RS_ERROR) begin
              r_drop <= 1'b1;
              r_ren  <= 1'b0;
              r_wen  <= 1'b0;
            end
          end
        end
        ABORT: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter with TIMEOUT=4.
module tb_mem_arbiter;

  localparam int W = 32;
  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;
  localparam logic [1:0] S_IDLE = 2'd0, S_IGRANT = 2'd1, S_DGRANT = 2'd2, S_ABORT = 2'd3;

  logic         CLK, nRST;
  logic         iREN, dREN, dWEN;
  logic [W-1:0] iaddr, daddr, dstore, ramload;
  logic [1:0]   ramstate;
  logic         iwait, dwait, ramREN, ramWEN, err;
  logic [W-1:0] iload, dload, ramaddr, ramstore;
  logic [1:0]   o_dbg_state;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.TIMEOUT(4), .WORD_W(W)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iwait(iwait), .iload(iload), .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err),
    .o_dbg_state(o_dbg_state)
  );

  // Clock and reset
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Both requesters must never see completion in the same cycle.
  always @(negedge CLK) begin
    checks++;
    if (!iwait && !dwait) begin
      errors++;
      $display("FAIL both_waits_low iwait=%0b dwait=%0b exp not both 0", iwait, dwait);
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0; iREN = 1'b1; iaddr = 32'h10; dREN = 1'b0; dWEN = 1'b0;
    daddr = '0; dstore = '0; ramload = 32'h5; ramstate = FREE;
    step(); step(); smp();
    checks++; if (o_dbg_state !== S_IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", o_dbg_state, S_IDLE); end
    checks++; if (ramREN !== 1'b0) begin errors++; $display("FAIL rst_ramREN got %0b exp 0", ramREN); end
    checks++; if (ramWEN !== 1'b0) begin errors++; $display("FAIL rst_ramWEN got %0b exp 0", ramWEN); end
    checks++; if (ramaddr !== 32'h0) begin errors++; $display("FAIL rst_ramaddr got %h exp 0", ramaddr); end
    checks++; if (ramstore !== 32'h0) begin errors++; $display("FAIL rst_ramstore got %h exp 0", ramstore); end
    checks++; if (iwait !== 1'b1 || dwait !== 1'b1) begin errors++; $display("FAIL rst_waits got %0b%0b exp 11", iwait, dwait); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %0b exp 0", err); end
    checks++; if (iload !== 32'h0 || dload !== 32'h0) begin errors++; $display("FAIL rst_loads got %h %h exp 0 0", iload, dload); end
    // Release reset; the first edge with nRST high must not grant.
    nRST = 1'b1;
    step(); smp();
    checks++; if (ramREN !== 1'b0 || o_dbg_state !== S_IDLE) begin errors++; $display("FAIL rel_no_grant ramREN=%0b state=%0d exp 0 0", ramREN, o_dbg_state); end
    step();
    iREN = 1'b0; ramstate = ACCESS; ramload = 32'h0000_00AA;
    smp();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h10) begin errors++; $display("FAIL rel_grant ramREN=%0b addr=%h exp 1 10", ramREN, ramaddr); end
    checks++; if (iwait !== 1'b0 || iload !== 32'hAA) begin errors++; $display("FAIL rel_done iwait=%0b iload=%h exp 0 aa", iwait, iload); end
    step();
    ramstate = FREE;
    smp();
    checks++; if (o_dbg_state !== S_IDLE || ramREN !== 1'b0) begin errors++; $display("FAIL rel_idle state=%0d ramREN=%0b exp 0 0", o_dbg_state, ramREN); end
  endtask

  task automatic test_read_busy();
    int n_ren;
    n_ren = 0;
    iREN = 1'b1; iaddr = 32'h40;
    step();
    ramstate = BUSY;
    smp();
    if (ramREN === 1'b1) n_ren++;
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h40) begin errors++; $display("FAIL rb_c1 ramREN=%0b addr=%h exp 1 40", ramREN, ramaddr); end
    checks++; if (iwait !== 1'b1 || iload !== 32'h0) begin errors++; $display("FAIL rb_c1_wait iwait=%0b iload=%h exp 1 0", iwait, iload); end
    step(); smp();
    if (ramREN === 1'b1) n_ren++;
    checks++; if (iwait !== 1'b1) begin errors++; $display("FAIL rb_c2_wait iwait=%0b exp 1", iwait); end
    step();
    ramstate = ACCESS; ramload = 32'h2400_0001;
    smp();
    if (ramREN === 1'b1) n_ren++;
    checks++; if (iwait !== 1'b0 || iload !== 32'h2400_0001) begin errors++; $display("FAIL rb_done iwait=%0b iload=%h exp 0 24000001", iwait, iload); end
    checks++; if (dwait !== 1'b1 || dload !== 32'h0) begin errors++; $display("FAIL rb_dside dwait=%0b dload=%h exp 1 0", dwait, dload); end
    iREN = 1'b0;
    step();
    ramstate = FREE;
    smp();
    if (ramREN === 1'b1) n_ren++;
    checks++; if (n_ren !== 3) begin errors++; $display("FAIL rb_ren_cycles got %0d exp 3", n_ren); end
    checks++; if (iwait !== 1'b1 || iload !== 32'h0 || o_dbg_state !== S_IDLE) begin errors++; $display("FAIL rb_after iwait=%0b iload=%h state=%0d exp 1 0 0", iwait, iload, o_dbg_state); end
  endtask

  task automatic test_priority();
    iREN = 1'b1; iaddr = 32'h44; dWEN = 1'b1; daddr = 32'h80; dstore = 32'hDEAD_BEEF;
    step();
    ramstate = ACCESS; ramload = 32'h0;
    smp();
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0) begin errors++; $display("FAIL pr_strobes wen=%0b ren=%0b exp 1 0", ramWEN, ramREN); end
    checks++; if (ramaddr !== 32'h80 || ramstore !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pr_wr_bus addr=%h store=%h exp 80 deadbeef", ramaddr, ramstore); end
    checks++; if (dwait !== 1'b0 || iwait !== 1'b1) begin errors++; $display("FAIL pr_wr_waits d=%0b i=%0b exp 0 1", dwait, iwait); end
    dWEN = 1'b0;
    step();
    ramstate = FREE;
    smp();
    checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || o_dbg_state !== S_IDLE) begin errors++; $display("FAIL pr_gap wen=%0b ren=%0b state=%0d exp 0 0 0", ramWEN, ramREN, o_dbg_state); end
    step();
    ramstate = ACCESS; ramload = 32'h1234_5678;
    smp();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h44) begin errors++; $display("FAIL pr_rd_bus ren=%0b addr=%h exp 1 44", ramREN, ramaddr); end
    checks++; if (iwait !== 1'b0 || iload !== 32'h1234_5678 || dwait !== 1'b1) begin errors++; $display("FAIL pr_rd_done i=%0b iload=%h d=%0b exp 0 12345678 1", iwait, iload, dwait); end
    iREN = 1'b0;
    step();
    ramstate = FREE;
    smp();
  endtask

  task automatic test_rw_both();
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h90; dstore = 32'h1111;
    step();
    ramstate = ACCESS;
    smp();
    checks++; if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'h1111) begin errors++; $display("FAIL rw_as_write wen=%0b ren=%0b store=%h exp 1 0 1111", ramWEN, ramREN, ramstore); end
    dREN = 1'b0; dWEN = 1'b0;
    step();
    ramstate = FREE;
    smp();
  endtask

  task automatic test_fair();
    logic exp_d;
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h500; iaddr = 32'h600;
    ramstate = ACCESS; ramload = 32'h77;
    step();
    for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARBITER_FAIR_EN
      exp_d = (k % 2 == 0);
`else
      exp_d = 1'b1;
`endif
      smp();
      checks++; if (dwait !== !exp_d || iwait !== exp_d) begin errors++; $display("FAIL fair_grant%0d dwait=%0b iwait=%0b exp %0b %0b", k, dwait, iwait, !exp_d, exp_d); end
      checks++; if (ramaddr !== (exp_d ? 32'h500 : 32'h600)) begin errors++; $display("FAIL fair_addr%0d got %h exp %h", k, ramaddr, exp_d ? 32'h500 : 32'h600); end
      if (k == 3) begin
        dREN = 1'b0; iREN = 1'b0;
      end
      step(); smp();
      checks++; if (o_dbg_state !== S_IDLE || dwait !== 1'b1 || iwait !== 1'b1) begin errors++; $display("FAIL fair_idle%0d state=%0d d=%0b i=%0b exp 0 1 1", k, o_dbg_state, dwait, iwait); end
      step();
    end
    ramstate = FREE;
    smp();
    checks++; if (o_dbg_state !== S_IDLE) begin errors++; $display("FAIL fair_end state=%0d exp 0", o_dbg_state); end
  endtask

  task automatic test_timeout();
    dREN = 1'b1; daddr = 32'h200;
    step();
    ramstate = BUSY; dREN = 1'b0;
    for (int c = 0; c < 4; c++) begin
      smp();
      checks++; if (ramREN !== 1'b1 || dwait !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL to_busy%0d ren=%0b dwait=%0b err=%0b exp 1 1 0", c, ramREN, dwait, err); end
      step();
    end
    smp();
    checks++; if (o_dbg_state !== S_ABORT || err !== 1'b1) begin errors++; $display("FAIL to_abort state=%0d err=%0b exp 3 1", o_dbg_state, err); end
    checks++; if (ramREN !== 1'b0 || ramWEN !== 1'b0 || dwait !== 1'b1) begin errors++; $display("FAIL to_abort_bus ren=%0b wen=%0b dwait=%0b exp 0 0 1", ramREN, ramWEN, dwait); end
    step();
    ramstate = FREE;
    smp();
    checks++; if (o_dbg_state !== S_IDLE || err !== 1'b0) begin errors++; $display("FAIL to_after state=%0d err=%0b exp 0 0", o_dbg_state, err); end
  endtask

  task automatic test_error();
    dREN = 1'b1; daddr = 32'h100;
    step();
    ramstate = ERROR;
    smp();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100 || dwait !== 1'b1) begin errors++; $display("FAIL er_first ren=%0b addr=%h dwait=%0b exp 1 100 1", ramREN, ramaddr, dwait); end
    dREN = 1'b0;
    step();
    ramstate = FREE;
    smp();
    checks++; if (ramREN !== 1'b0 || dwait !== 1'b1 || o_dbg_state !== S_DGRANT) begin errors++; $display("FAIL er_drop ren=%0b dwait=%0b state=%0d exp 0 1 2", ramREN, dwait, o_dbg_state); end
    step();
    ramstate = ACCESS; ramload = 32'hCAFE_0001;
    smp();
    checks++; if (ramREN !== 1'b1 || ramaddr !== 32'h100) begin errors++; $display("FAIL er_reissue ren=%0b addr=%h exp 1 100", ramREN, ramaddr); end
    checks++; if (dwait !== 1'b0 || dload !== 32'hCAFE_0001) begin errors++; $display("FAIL er_done dwait=%0b dload=%h exp 0 cafe0001", dwait, dload); end
    step();
    ramstate = FREE;
    smp();
    checks++; if (ramREN !== 1'b0 || o_dbg_state !== S_IDLE || dload !== 32'h0) begin errors++; $display("FAIL er_after ren=%0b state=%0d dload=%h exp 0 0 0", ramREN, o_dbg_state, dload); end
  endtask

  task automatic test_error_timeout();
    dREN = 1'b1; daddr = 32'h180;
    step();
    ramstate = ERROR; dREN = 1'b0;
    step();
    ramstate = FREE;
    step();
    ramstate = BUSY;
    step();
    smp();
    checks++; if (ramREN !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL et_c4 ren=%0b err=%0b exp 1 0", ramREN, err); end
    step(); smp();
    checks++; if (err !== 1'b1 || o_dbg_state !== S_ABORT) begin errors++; $display("FAIL et_abort err=%0b state=%0d exp 1 3", err, o_dbg_state); end
    step();
    ramstate = FREE;
    smp();
  endtask

  task automatic test_reset_mid();
    dWEN = 1'b1; daddr = 32'h300; dstore = 32'h55;
    step();
    ramstate = BUSY;
    smp();
    checks++; if (ramWEN !== 1'b1 || ramaddr !== 32'h300) begin errors++; $display("FAIL rm_write wen=%0b addr=%h exp 1 300", ramWEN, ramaddr); end
    nRST = 1'b0;
    step(); smp();
    checks++; if (ramWEN !== 1'b0 || ramREN !== 1'b0 || o_dbg_state !== S_IDLE) begin errors++; $display("FAIL rm_strobes wen=%0b ren=%0b state=%0d exp 0 0 0", ramWEN, ramREN, o_dbg_state); end
    checks++; if (ramaddr !== 32'h0 || ramstore !== 32'h0) begin errors++; $display("FAIL rm_bus addr=%h store=%h exp 0 0", ramaddr, ramstore); end
    checks++; if (iwait !== 1'b1 || dwait !== 1'b1 || err !== 1'b0) begin errors++; $display("FAIL rm_outs i=%0b d=%0b err=%0b exp 1 1 0", iwait, dwait, err); end
    nRST = 1'b1; dWEN = 1'b0; ramstate = FREE;
    step(); step(); smp();
  endtask

  // Test sequence and final report
  initial begin
    test_reset();
    test_read_busy();
    test_priority();
    test_rw_both();
    test_fair();
    test_timeout();
    test_error();
    test_error_timeout();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
